// File: rtl/clk_div.sv
// Divides CLK_IN by 2*K into a registered 50%-duty CLK_OUT.
// Optional: define CLK_DIV_TICK_EN to add TICK, a one-cycle strobe following each CLK_OUT toggle.
`timescale 1ns/1ps

module clk_div #(
    parameter int K = 10,
    parameter int N = 4
) (
    input  logic CLK_IN,
    input  logic RST,
`ifdef CLK_DIV_TICK_EN
    output logic TICK,
`endif
    output logic CLK_OUT
);

    // An out-of-range K must stop elaboration rather than build a wrong divider.
    generate
        if (K < 1 || K > 2**N) begin : g_bad_param
            $error("clk_div: K=%0d outside legal range 1..2**N (N=%0d)", K, N);
        end
    endgenerate

    localparam logic [N-1:0] LAST = N'(K - 1);

    logic [N-1:0] cnt;
    logic         wrap;

    assign wrap = (cnt == LAST);

    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            cnt     <= '0;
            CLK_OUT <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            CLK_OUT <= ~CLK_OUT;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

`ifdef CLK_DIV_TICK_EN
    // Registered from the same wrap condition, so TICK is high in the cycle the new CLK_OUT shows.
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            TICK <= 1'b0;
        end else begin
            TICK <= wrap;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: three instances (K=10/N=4, K=1/N=1, K=16/N=4) checked against an edge-count model.
`timescale 1ns/1ps

module tb_clk_div;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #10 clk = ~clk;

    logic out_a, out_b, out_c;
`ifdef CLK_DIV_TICK_EN
    logic tick_a, tick_b, tick_c;
`endif

    clk_div #(.K(10), .N(4)) dut_a (
        .CLK_IN (clk),
        .RST    (rst_n),
`ifdef CLK_DIV_TICK_EN
        .TICK   (tick_a),
`endif
        .CLK_OUT(out_a)
    );

    clk_div #(.K(1), .N(1)) dut_b (
        .CLK_IN (clk),
        .RST    (rst_n),
`ifdef CLK_DIV_TICK_EN
        .TICK   (tick_b),
`endif
        .CLK_OUT(out_b)
    );

    clk_div #(.K(16), .N(4)) dut_c (
        .CLK_IN (clk),
        .RST    (rst_n),
`ifdef CLK_DIV_TICK_EN
        .TICK   (tick_c),
`endif
        .CLK_OUT(out_c)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Per instance byte: bit0 CLK_OUT, bit1 TICK, bits[7:4] cnt, derived from edges since release.
    logic [23:0] exp_q[$];
    int edges = 0;

    function automatic logic [7:0] model(input int k, input int e);
        logic [7:0] r;
        r      = '0;
        r[0]   = ((e / k) % 2) == 1;
        r[1]   = (e > 0) && ((e % k) == 0);
        r[7:4] = 4'(e % k);
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) edges = 0;
        else        edges = edges + 1;
        exp_q.push_back({model(16, edges), model(1, edges), model(10, edges)});
    end

    always @(negedge clk) begin
        logic [23:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_a", 32'(out_a), 32'(e[0]));
            check("cnt_a", 32'(dut_a.cnt), 32'(e[7:4]));
            check("out_b", 32'(out_b), 32'(e[8]));
            check("cnt_b", 32'(dut_b.cnt), 32'(e[15:12]));
            check("out_c", 32'(out_c), 32'(e[16]));
            check("cnt_c", 32'(dut_c.cnt), 32'(e[23:20]));
`ifdef CLK_DIV_TICK_EN
            check("tick_a", 32'(tick_a), 32'(e[1]));
            check("tick_b", 32'(tick_b), 32'(e[9]));
            check("tick_c", 32'(tick_c), 32'(e[17]));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_state(input string tag);
        check({tag, "_out_a"}, 32'(out_a), 32'd0);
        check({tag, "_out_b"}, 32'(out_b), 32'd0);
        check({tag, "_out_c"}, 32'(out_c), 32'd0);
        check({tag, "_cnt_a"}, 32'(dut_a.cnt), 32'd0);
        check({tag, "_cnt_c"}, 32'(dut_c.cnt), 32'd0);
`ifdef CLK_DIV_TICK_EN
        check({tag, "_tick_a"}, 32'(tick_a), 32'd0);
        check({tag, "_tick_b"}, 32'(tick_b), 32'd0);
`endif
    endtask

    // Changes land 15 ns after a rising edge, clear of both clock edges.
    task automatic set_reset(input logic v);
        @(posedge clk);
        #15 rst_n = v;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #15;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen_high;

        // Assert reset before any clock edge: outputs must clear with no clock.
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_no_clk");

        #100;
        check_reset_state("reset_hold");

        // Steady state: K=16 needs 640 ns per period, 200 cycles covers > 6 of them.
        set_reset(1'b1);
        run_cycles(200 + $urandom_range(0, 9));

        // Find a cycle where the K=10 output is high, then reset between edges.
        seen_high = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_a === 1'b1) begin
                seen_high = 1'b1;
                break;
            end
            run_cycles(1);
        end
        check("wait_out_a_high", 32'(seen_high), 32'd1);

        rst_n = 1'b0;
        #1 check_reset_state("async_mid_run");

        run_cycles(3);
        check_reset_state("reset_held_mid_run");

        set_reset(1'b1);
        run_cycles(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
